uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//  UART transmit sequencer between the TX FIFO and the serial line. It pops one byte per frame from a
//  first-word-fall-through FIFO and sends start, data (LSB first), optional parity and stop bits.
//  Bit timing comes from an internal bit timer that this block enables, clears and sequences.
//  Back-to-back frames have no idle gap while the FIFO is non-empty.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); legal >= 1
//  DATA_BITS     8    data bits per frame; legal 5..8
//  STOP_BITS     1    stop bits per frame; legal 1..2
//  PARITY_EN     0    1 = insert parity bit after the data bits
//  PARITY_ODD    0    1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-high reset
//  fifo_empty    in   1          TX FIFO empty
//  fifo_rd_data  in   DATA_BITS  FIFO head word; valid whenever fifo_empty=0 (FWFT)
//  fifo_rd_en    out  1          pop strobe; one cycle per frame
//  tx            out  1          serial line; registered; idles high
//  busy          out  1          frame in progress (state != IDLE)
//  tx_done       out  1          one-cycle pulse in the final clk of the last stop bit
// BEHAVIOUR
//  - Reset values: tx=1, busy=0, fifo_rd_en=0, tx_done=0, state=IDLE, bit counter=0, timer cleared.
//  - fifo_rd_en is combinational from state, timer tick and fifo_empty. It is never asserted when fifo_empty=1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    - IDLE & !fifo_empty (cycle T): fifo_rd_en=1, latch fifo_rd_data into the shift register, go to START.
//      tx=0 from T+1; busy=1 from T+1.
//    - START -> DATA on bit_tick.
//    - DATA: shift LSB-first; after DATA_BITS ticks go to PARITY if PARITY_EN=1, else to STOP.
//    - PARITY -> STOP on bit_tick. Parity bit = ^data XOR PARITY_ODD.
//    - STOP: tx=1 for STOP_BITS bit periods. On the last tick, tx_done=1.
//      If !fifo_empty in that same cycle: fifo_rd_en=1, latch the next byte, go to START (next start bit at +1).
//      Otherwise go to IDLE.
//  - Bit timer: counts 0..CLKS_PER_BIT-1 while enabled; bit_tick = (count == CLKS_PER_BIT-1).
//    The count wraps to 0 on tick. It is held at 0 in IDLE, so every bit is exactly CLKS_PER_BIT cycles.
//  - Frame length = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles, measured from the first tx=0 cycle.
//  - CLKS_PER_BIT=1: bit_tick is constant 1 while enabled; one cycle per bit; back-to-back still gapless.
//  - Data-bit counter width is $clog2(DATA_BITS+1). Stop-bit counter is 1 bit.
//  - The shift register is loaded only on a pop. Changes on fifo_rd_data mid-frame have no effect.
//  - Reset mid-frame: the frame is aborted and the byte is lost. Outputs take reset values next cycle;
//    tx=1 immediately after the reset edge.
//  - fifo_empty rising mid-frame: no effect until the STOP decision point.
//  - Illegal parameters cause an elaboration-time $error.
// STRUCTURE
//  - uart_pkg: typedef enum logic [2:0] tx_state_e {IDLE,START,DATA,PARITY,STOP}; localparam DEFAULT_CLKS_PER_BIT=868.
//  - Sub-module: bit_timer (synchronous-reset counter; inputs clk, reset, enable; output tick),
//    parameterised by CLKS_PER_BIT.
//  - Top level: FSM, shift register, data/stop bit counters, parity accumulator, registered tx.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1. Push 0xA5, 8N1 -> single fifo_rd_en pulse. tx pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 total).
//     tx_done in the 40th cycle, then busy=0.
//  2. Push 0x3C,0xC3 together -> two rd_en pulses 40 cycles apart. Second start bit directly follows the stop bit
//     (no extra high cycle).
//  3. PARITY_EN=1, even, byte 0x07 -> parity bit=1. PARITY_ODD=1 -> parity bit=0. Frame is 44 cycles.
//  4. STOP_BITS=2, byte 0x00 -> tx high for 8 cycles after the data bits. tx_done only at the end of the 2nd stop bit.
//  5. Reset asserted 13 cycles into the 0xFF frame -> tx=1, busy=0 next cycle.
//     A subsequent push of 0x55 transmits cleanly from a fresh start bit.
//  6. CLKS_PER_BIT=1, FIFO empty for 20 cycles then 0x81 -> no rd_en and tx=1 while empty.
//     Then a 10-cycle frame: 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and defaults for the UART transmit path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_tx_ctrl_bit_timer.sv
// bit_timer: bit-period counter, held at zero while disabled, wraps on tick
module bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset || !enable || tick) count <= '0;
    else count <= count + 1'b1;
  assign tick = enable && count == LAST;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: pops bytes from a FWFT FIFO and serialises start/data/parity/stop frames
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(DATA_BITS + 1);
  tx_state_e state, nxt;
  logic tick, tx_nxt, par, dlast, slast, scnt;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0] dcnt;
  if (CLKS_PER_BIT < 1 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad
    $error("uart_tx_ctrl: illegal CLKS_PER_BIT/DATA_BITS/STOP_BITS");
  end
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .enable(busy),
    .tick(tick)
  );
  assign dlast = dcnt == CW'(DATA_BITS - 1);
  assign slast = scnt == 1'(STOP_BITS - 1);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      shreg <= '0;
      par   <= 1'b0;
      dcnt  <= '0;
      scnt  <= 1'b0;
    end else begin
      state <= nxt;
      tx    <= tx_nxt;
      if (fifo_rd_en) begin
        shreg <= fifo_rd_data;
        par   <= ^fifo_rd_data ^ PARITY_ODD;
      end else if (state == DATA && tick) shreg <= shreg >> 1;
      if (state == DATA && tick) dcnt <= dlast ? '0 : dcnt + 1'b1;
      if (state == STOP && tick) scnt <= slast ? 1'b0 : scnt + 1'b1;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fifo_empty ? IDLE : START;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = tick && dlast ? (PARITY_EN ? PARITY : STOP) : DATA;
      PARITY:  nxt = tick ? STOP : PARITY;
      STOP:    nxt = tick && slast ? (fifo_empty ? IDLE : START) : STOP;
      default: nxt = IDLE;
    endcase
  end
  // tx is registered, so it is computed from the state being entered next cycle
  always_comb begin
    busy       = state != IDLE;
    tx_done    = state == STOP && tick && slast;
    fifo_rd_en = !fifo_empty && (state == IDLE || tx_done);
    tx_nxt     = nxt == START  ? 1'b0 :
                 nxt == DATA   ? (state == DATA && tick ? shreg[1] : shreg[0]) :
                 nxt == PARITY ? par : 1'b1;
  end
endmodule
